fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first PC fetched after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the value driven on InstrD when the slot is invalid.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising edge) and rst_n input 1 (asynchronous, active-low).
REQ-004 SHALL have the following ports, one per line:
- StallF  input  1  hold PCF and the IF/ID register.
- FlushD  input  1  invalidate the IF/ID register.
- PCSrc  input  1  single-cycle redirect pulse from execute.
- PCTarget  input  32  redirect address.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address.
- imem_ready  input  1  imem_rdata valid this cycle.
- imem_rdata  input  32  fetched word.
- InstrD  output  32  decode-stage instruction; InstrD[6:0] drives main decoder op.
- PCD  output  32  PC of InstrD.
- PCPlus4D  output  32  PCD+4.
- ValidD  output  1  InstrD holds a real instruction.

Function
REQ-005 SHALL implement an FSM with states FETCH, HOLD and DISCARD.
REQ-006 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PCF, held stable until imem_ready.
REQ-007 On FETCH & imem_ready & !StallF & !redirect, SHALL load InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1, and set PCF<=PCF+4; latency SHALL be one cycle from ready to decode.
REQ-008 On FETCH & imem_ready & StallF, SHALL capture imem_rdata/PCF in a skid register, set PCF<=PCF+4 and enter HOLD.
REQ-009 In HOLD, imem_req SHALL be 0 and the IF/ID register SHALL hold; on !StallF, the skid contents SHALL move to IF/ID and the FSM SHALL return to FETCH.
REQ-010 StallF without a pending response SHALL freeze PCF and IF/ID, with imem_req remaining asserted.
REQ-011 PCSrc SHALL latch PCTarget into a redirect register; redirect SHALL take priority over sequential PC update and over a skid hold, discarding skid contents.
REQ-012 A redirect in FETCH with no imem_ready in the same cycle SHALL enter DISCARD, keeping imem_req/imem_addr at the old PC until imem_ready, dropping that data, then setting PCF<=target and entering FETCH.
REQ-013 A redirect coinciding with imem_ready SHALL drop the data and set PCF<=target in the same edge.
REQ-014 FlushD SHALL set ValidD=0 and InstrD=NOP_INSTR on the next edge, overriding a simultaneous load and StallF for the IF/ID register only.
REQ-015 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-016 A second PCSrc while in DISCARD SHALL overwrite the redirect register (last wins).

Reset
REQ-017 While rst_n=0: PCF=RESET_VECTOR, FSM=FETCH, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, skid empty, redirect clear, imem_req=0.
REQ-018 Reset SHALL abort any in-flight fetch; the first request after deassertion SHALL be to RESET_VECTOR.

Configuration
REQ-019 With FETCH_MISALIGN_CHECK_EN defined, the block SHALL add output MisalignF (1 bit); a PCTarget with [1:0]!=0 SHALL be ignored for redirect and SHALL pulse MisalignF for one cycle.
REQ-020 Without FETCH_MISALIGN_CHECK_EN, the MisalignF port SHALL be absent and PCTarget[1:0] SHALL be forced to 0.

Verification
REQ-021 Reset, imem_ready=1 every cycle -> imem_addr 0,4,8; InstrD follows one cycle later; ValidD=1 from the second edge.
REQ-022 imem_ready with StallF=1 for 3 cycles -> imem_req=0 in HOLD, InstrD unchanged; after release, skid word appears, next fetch is PC+4.
REQ-023 PCSrc=1, PCTarget=0x100 while imem_ready=0 -> DISCARD, late word dropped, next imem_addr=0x100, no ValidD for the old PC.
REQ-024 FlushD with simultaneous imem_ready -> ValidD=0, InstrD=0x00000013.
REQ-025 PCF=0xFFFFFFFC fetched -> next imem_addr=0x00000000.
REQ-026 rst_n low mid-DISCARD -> all outputs at reset values asynchronously; first request to RESET_VECTOR.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, skid buffer and redirect handling
//
// Purpose:
//   Drives a simple request/ready instruction memory, keeps the fetch PC (PCF)
//   and delivers fetched words into the IF/ID pipeline register. A one-entry
//   skid register absorbs a response that arrives while decode is stalled, and
//   a redirect register remembers an execute-stage branch target until the
//   outstanding fetch for the old PC has been returned and dropped.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   Defined   : adds output MisalignF; a PCTarget with [1:0] != 0 is ignored
//               and MisalignF pulses for the cycle of that PCSrc.
//   Undefined : PCTarget[1:0] is forced to 0 and MisalignF does not exist.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   StallF      in   1   hold PCF and the IF/ID register
//   FlushD      in   1   invalidate the IF/ID register
//   PCSrc       in   1   single-cycle redirect pulse from execute
//   PCTarget    in   32  redirect address
//   imem_req    out  1   fetch request
//   imem_addr   out  32  fetch address
//   imem_ready  in   1   imem_rdata valid this cycle
//   imem_rdata  in   32  fetched word
//   InstrD      out  32  decode-stage instruction (NOP_INSTR when invalid)
//   PCD         out  32  PC of InstrD
//   PCPlus4D    out  32  PCD + 4
//   ValidD      out  1   InstrD holds a real instruction
//   MisalignF   out  1   misaligned redirect target seen (macro builds only)

module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        MisalignF
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        started_q;

  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        load_ifid;
  logic [31:0] ld_instr;
  logic [31:0] ld_pc;

  logic        pcsrc_ok;
  logic [31:0] target_in;
  logic        redirect_pending;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic        fire;

  // Redirect acceptance: either reject misaligned targets or align them.
`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (PCTarget[1:0] != 2'b00);
  assign pcsrc_ok   = PCSrc & ~misaligned;
  assign target_in  = PCTarget;
  assign MisalignF  = PCSrc & misaligned;
`else
  logic unused_target_bits;
  assign unused_target_bits = ^PCTarget[1:0];
  assign pcsrc_ok  = PCSrc;
  assign target_in = {PCTarget[31:2], 2'b00};
`endif

  // A PCSrc arriving this cycle wins over an older latched target.
  assign redirect_pending = pcsrc_ok | redir_valid_q;
  assign redirect_pc      = pcsrc_ok ? target_in : redir_pc_q;

  assign pc_plus4 = pcf_q + 32'd4;

  // started_q keeps the request low for the first cycle out of reset, so
  // no request is ever presented while rst_n is asserted.
  assign imem_req  = started_q & (state_q != HOLD);
  assign imem_addr = pcf_q;
  assign fire      = imem_req & imem_ready;

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    // Every accepted PCSrc is recorded; the state logic clears it when used.
    redir_valid_d = redir_valid_q | pcsrc_ok;
    redir_pc_d    = pcsrc_ok ? target_in : redir_pc_q;
    load_ifid     = 1'b0;
    ld_instr      = imem_rdata;
    ld_pc         = pcf_q;

    case (state_q)
      FETCH: begin
        if (redirect_pending) begin
          if (fire || !started_q) begin
            // Nothing outstanding (or it returns now and is dropped):
            // redirect takes effect on this edge.
            pcf_d         = redirect_pc;
            redir_valid_d = 1'b0;
          end else begin
            // The request for the old PC is in flight; wait for it and
            // throw it away before switching to the target.
            state_d = DISCARD;
          end
        end else if (fire) begin
          pcf_d = pc_plus4;
          if (StallF) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pcf_q;
            state_d      = HOLD;
          end else begin
            load_ifid = 1'b1;
          end
        end
      end

      HOLD: begin
        if (redirect_pending) begin
          // Skid word belongs to the wrong path; drop it.
          skid_instr_d  = 32'd0;
          skid_pc_d     = 32'd0;
          pcf_d         = redirect_pc;
          redir_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (!StallF) begin
          load_ifid = 1'b1;
          ld_instr  = skid_instr_q;
          ld_pc     = skid_pc_q;
          state_d   = FETCH;
        end
      end

      DISCARD: begin
        // imem_req/imem_addr stay on the old PC until it is answered.
        if (imem_ready) begin
          pcf_d         = redirect_pc;
          redir_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // IF/ID next value; FlushD overrides both a load and a stall hold.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (load_ifid) begin
      instr_d = ld_instr;
      pcd_d   = ld_pc;
      pcp4_d  = ld_pc + 32'd4;
      valid_d = 1'b1;
    end
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pcf_q         <= RESET_VECTOR;
      started_q     <= 1'b0;
      skid_instr_q  <= 32'd0;
      skid_pc_q     <= 32'd0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      instr_q       <= NOP_INSTR;
      pcd_q         <= 32'd0;
      pcp4_q        <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcf_q         <= pcf_d;
      started_q     <= 1'b1;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      instr_q       <= instr_d;
      pcd_q         <= pcd_d;
      pcp4_q        <= pcp4_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        FlushD;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_stage #(
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INSTR   (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .FlushD    (FlushD),
    .PCSrc     (PCSrc),
    .PCTarget  (PCTarget),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [31:0] target;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [31:0] e_pcd;
    logic [31:0] e_pcp4;
  } vec_t;

  vec_t vecs[23];
  int   n_cmp;
  int   n_fail;

  function automatic vec_t mk(logic s, logic f, logic p, logic [31:0] t,
                              logic r, logic [31:0] d, logic er,
                              logic [31:0] ea, logic [31:0] ei, logic ev,
                              logic [31:0] ep, logic [31:0] e4);
    vec_t v;
    v.stall = s; v.flush = f; v.pcsrc = p; v.target = t;
    v.ready = r; v.rdata = d; v.e_req = er; v.e_addr = ea;
    v.e_instr = ei; v.e_valid = ev; v.e_pcd = ep; v.e_pcp4 = e4;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic er, input logic [31:0] ea,
                         input logic [31:0] ei, input logic ev,
                         input logic [31:0] ep, input logic [31:0] e4);
    chk("imem_req", idx, {31'd0, imem_req}, {31'd0, er});
    chk("imem_addr", idx, imem_addr, ea);
    chk("InstrD", idx, InstrD, ei);
    chk("ValidD", idx, {31'd0, ValidD}, {31'd0, ev});
    chk("PCD", idx, PCD, ep);
    chk("PCPlus4D", idx, PCPlus4D, e4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    StallF = 1'b0; FlushD = 1'b0; PCSrc = 1'b0; PCTarget = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0;

    // stall flush pcsrc target ready rdata | req addr instr valid pcd pcp4
    vecs[0]  = mk(0,0,0,32'h0,1,32'h0,          0,32'h0,NOP,0,32'h0,32'h0);
    vecs[1]  = mk(0,0,0,32'h0,1,32'hA000_0000,  1,32'h0,NOP,0,32'h0,32'h0);
    vecs[2]  = mk(0,0,0,32'h0,1,32'hA000_0004,  1,32'h4,32'hA000_0000,1,32'h0,32'h4);
    vecs[3]  = mk(1,0,0,32'h0,1,32'hA000_0008,  1,32'h8,32'hA000_0004,1,32'h4,32'h8);
    vecs[4]  = mk(1,0,0,32'h0,0,32'h0,          0,32'hC,32'hA000_0004,1,32'h4,32'h8);
    vecs[5]  = mk(1,0,0,32'h0,0,32'h0,          0,32'hC,32'hA000_0004,1,32'h4,32'h8);
    vecs[6]  = mk(0,0,0,32'h0,0,32'h0,          0,32'hC,32'hA000_0004,1,32'h4,32'h8);
    vecs[7]  = mk(1,0,0,32'h0,0,32'h0,          1,32'hC,32'hA000_0008,1,32'h8,32'hC);
    vecs[8]  = mk(0,1,0,32'h0,1,32'hA000_000C,  1,32'hC,32'hA000_0008,1,32'h8,32'hC);
    vecs[9]  = mk(0,0,1,32'h100,0,32'h0,        1,32'h10,NOP,0,32'hC,32'h10);
    vecs[10] = mk(0,0,0,32'h0,0,32'h0,          1,32'h10,NOP,0,32'hC,32'h10);
    vecs[11] = mk(0,0,0,32'h0,1,32'hA000_0010,  1,32'h10,NOP,0,32'hC,32'h10);
    vecs[12] = mk(0,0,0,32'h0,1,32'hB000_0100,  1,32'h100,NOP,0,32'hC,32'h10);
    vecs[13] = mk(0,0,1,32'hFFFF_FFFC,1,32'hDEAD_BEEF,
                  1,32'h104,32'hB000_0100,1,32'h100,32'h104);
    vecs[14] = mk(0,0,0,32'h0,1,32'hB000_0FFC,
                  1,32'hFFFF_FFFC,32'hB000_0100,1,32'h100,32'h104);
    vecs[15] = mk(0,0,1,32'h300,0,32'h0,        1,32'h0,32'hB000_0FFC,1,32'hFFFF_FFFC,32'h0);
    vecs[16] = mk(0,0,1,32'h400,0,32'h0,        1,32'h0,32'hB000_0FFC,1,32'hFFFF_FFFC,32'h0);
    vecs[17] = mk(0,0,0,32'h0,1,32'hDEAD_BEEF,  1,32'h0,32'hB000_0FFC,1,32'hFFFF_FFFC,32'h0);
    vecs[18] = mk(0,0,1,32'h503,1,32'hDEAD_BEEF,1,32'h400,32'hB000_0FFC,1,32'hFFFF_FFFC,32'h0);
    vecs[19] = mk(1,0,0,32'h0,1,32'hC000_0500,  1,32'h500,32'hB000_0FFC,1,32'hFFFF_FFFC,32'h0);
    vecs[20] = mk(1,0,1,32'h600,0,32'h0,        0,32'h504,32'hB000_0FFC,1,32'hFFFF_FFFC,32'h0);
    vecs[21] = mk(0,0,0,32'h0,1,32'hC000_0600,  1,32'h600,32'hB000_0FFC,1,32'hFFFF_FFFC,32'h0);
    vecs[22] = mk(0,0,0,32'h0,0,32'h0,          1,32'h604,32'hC000_0600,1,32'h600,32'h604);

    // Reset values while rst_n is held low.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all(100, 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      StallF     = vecs[i].stall;
      FlushD     = vecs[i].flush;
      PCSrc      = vecs[i].pcsrc;
      PCTarget   = vecs[i].target;
      imem_ready = vecs[i].ready;
      imem_rdata = vecs[i].rdata;
      #1;
      chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
              vecs[i].e_valid, vecs[i].e_pcd, vecs[i].e_pcp4);
    end

    // Enter DISCARD, then assert reset between clock edges.
    @(negedge clk);
    StallF = 1'b0; FlushD = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'h700; imem_ready = 1'b0;
    @(posedge clk);
    #2;
    PCSrc = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all(200, 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hE000_0000;
    #1;
    chk("imem_req", 201, {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    chk_all(202, 1'b1, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk_all(203, 1'b1, 32'h4, 32'hE000_0000, 1'b1, 32'h0, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
